// File: rtl/sha256d_second_stage_if.sv
// sha256d_second_stage_if
//   Groups every non-clock signal of the double-SHA256 second-stage controller.
//   There are three groups: the first-pass digest input, the link to the second
//   SHA256 core, and the result output.
//
// Handshake rule (in_* and out_*): a transfer happens on a rising CLK edge where
// valid and ready are both 1. A producer keeps valid and its payload stable
// until that transfer. The ready side may not depend on valid.
//
// Modports
//   slave  : the controller's view (drives in_ready, core_*_in, core_write_en, out_*)
//   master : the environment's view (first-pass core, second core, consumer)
interface sha256d_second_stage_if #(
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [255:0]     in_digest;
  logic [TAG_W-1:0] in_tag;
  logic [255:0]     target;

  logic             core_write_en;
  logic [511:0]     core_block_in;
  logic [255:0]     core_digest_in;
  logic [255:0]     core_digest_out;
  logic             core_valid_out;

  logic             out_valid;
  logic             out_ready;
  logic [255:0]     out_hash;
  logic             out_hit;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_digest, in_tag, target,
    input  core_digest_out, core_valid_out,
    input  out_ready,
    output in_ready,
    output core_write_en, core_block_in, core_digest_in,
    output out_valid, out_hash, out_hit, out_tag
  );

  modport master (
    output in_valid, in_digest, in_tag, target,
    output core_digest_out, core_valid_out,
    output out_ready,
    input  in_ready,
    input  core_write_en, core_block_in, core_digest_in,
    input  out_valid, out_hash, out_hit, out_tag
  );
endinterface

// File: rtl/sha256d_second_stage.sv
// sha256d_second_stage
//   Second pass of double SHA256. The block takes a 256-bit first-pass digest
//   and pads it into a single 512-bit block. It then runs an iterative SHA256
//   core over that block with the standard IV. It captures the result,
//   compares the byte-reversed hash against a mining target, and returns
//   hash, hit flag and job tag. Only one job is in flight at a time.
//
// Ports
//   CLK        clock
//   RST        asynchronous, active-low reset
//   bus        sha256d_second_stage_if.slave (input, core and output groups)
//   dbg_state  current FSM state (IDLE=0, RUN=1, WAIT=2, OUT=3)
//
// Timing: the input handshake happens at edge E0. core_write_en is high for
// the 66 cycles that follow. The core result is sampled one cycle later, and
// out_valid rises in the cycle after that.
module sha256d_second_stage #(
  parameter int TAG_W = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  sha256d_second_stage_if.slave   bus,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Count of the last write_en cycle (the window is counted 0..65).
  localparam logic [6:0] LAST_ROUND = 7'd65;

  state_t           state;
  logic [6:0]       cnt;
  logic             write_en;
  logic [511:0]     block;
  logic [TAG_W-1:0] tag_q;
  logic [255:0]     target_q;
  logic             out_valid_q;
  logic [255:0]     out_hash_q;
  logic             out_hit_q;
  logic [TAG_W-1:0] out_tag_q;

  // Mining targets compare against the hash read as a little-endian number.
  // Byte 0 of the core word order (bits 7:0) becomes the most significant byte.
  function automatic logic [255:0] byte_rev(input logic [255:0] h);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[8*i +: 8] = h[255-8*i -: 8];
    end
    return r;
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      cnt         <= '0;
      write_en    <= 1'b0;
      block       <= '0;
      tag_q       <= '0;
      target_q    <= '0;
      out_valid_q <= 1'b0;
      out_hash_q  <= '0;
      out_hit_q   <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // in_ready is 1 in IDLE whenever reset is released, so in_valid
          // alone qualifies the accept here.
          if (bus.in_valid) begin
            // The message is 256 bits: pad with a 1 bit, zeros, and a 64-bit
            // length field holding 256 (0x100).
            block    <= {bus.in_digest, 32'h80000000, 192'h0, 32'h00000100};
            tag_q    <= bus.in_tag;
            target_q <= bus.target;
            cnt      <= '0;
            write_en <= 1'b1;
            state    <= S_RUN;
          end
        end

        S_RUN: begin
          if (cnt == LAST_ROUND) begin
            write_en <= 1'b0;
            state    <= S_WAIT;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end

        S_WAIT: begin
          // The core cleared its previous valid level during the first
          // write_en cycle, so any 1 seen here belongs to this job.
          if (bus.core_valid_out) begin
            out_hash_q  <= bus.core_digest_out;
            out_hit_q   <= (byte_rev(bus.core_digest_out) <= target_q);
            out_tag_q   <= tag_q;
            out_valid_q <= 1'b1;
            state       <= S_OUT;
          end
        end

        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Gating with RST keeps in_ready low while reset is held. It also lets
  // in_ready rise in the first cycle after release.
  assign bus.in_ready       = (state == S_IDLE) && RST;
  assign bus.core_write_en  = write_en;
  assign bus.core_block_in  = block;
  assign bus.core_digest_in = SHA256_IV;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_hash       = out_hash_q;
  assign bus.out_hit        = out_hit_q;
  assign bus.out_tag        = out_tag_q;
  assign dbg_state          = state;

endmodule

// File: tb/tb_sha256d_second_stage.sv
// tb_sha256d_second_stage
//   Bench for sha256d_second_stage. A behavioural iterative SHA256 core drives
//   the core_* inputs. The bench applies a table of known vectors, then a
//   random set checked against a reference SHA256 model, then a reset-in-RUN
//   sequence.
module tb_sha256d_second_stage;

  localparam int TAG_W = 32;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] ABC_D1 =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] ABC_D2 =
    256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
  localparam logic [255:0] ABC_REV =
    256'h58636c3ec08c12d55aedda056d602d5bcca72d8df6a69b519b72d32dc2428b4f;
  localparam logic [255:0] ABC_REV_M1 =
    256'h58636c3ec08c12d55aedda056d602d5bcca72d8df6a69b519b72d32dc2428b4e;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [1:0] dbg_state;
  always #5 CLK = ~CLK;

  sha256d_second_stage_if #(.TAG_W(TAG_W)) bus ();

  sha256d_second_stage #(.TAG_W(TAG_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- reference SHA256 ----------------
  logic [31:0] k_tab [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256_block(input logic [255:0] iv, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    for (int i = 0; i < 8; i++) hv[i] = iv[255-32*i -: 32];
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hv[i];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_tab[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) hv[i] = hv[i] + v[i];
    return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
  endfunction

  function automatic logic [511:0] pad_block(input logic [255:0] d);
    return {d, 32'h80000000, 192'h0, 32'h00000100};
  endfunction

  function automatic logic [255:0] rev_bytes(input logic [255:0] h);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[255-8*i -: 8] = h[8*i +: 8];
    return r;
  endfunction

  // ---------------- behavioural second core ----------------
  // Produces its result after 66 write_en cycles. valid is a level that drops
  // on the next write_en cycle.
  int           core_cnt = 0;
  logic         core_valid = 1'b0;
  logic [255:0] core_digest = '0;
  assign bus.core_valid_out  = core_valid;
  assign bus.core_digest_out = core_digest;

  always @(posedge CLK) begin
    if (bus.core_write_en) begin
      if (core_cnt == 65) begin
        core_valid  <= 1'b1;
        core_digest <= sha256_block(bus.core_digest_in, bus.core_block_in);
        core_cnt    <= 0;
      end else begin
        core_valid <= 1'b0;
        core_cnt   <= core_cnt + 1;
      end
    end else begin
      core_cnt <= 0;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [255:0] exp_q [$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic wait_ready();
    for (int i = 0; i < 300 && bus.in_ready !== 1'b1; i++) @(negedge CLK);
    check("in_ready_idle", bus.in_ready, 1);
  endtask

  task automatic run_job(input logic [255:0] digest, input logic [31:0] tag,
                         input logic [255:0] tgt, input logic exp_hit, input int hold);
    logic [511:0] exp_blk;
    logic [255:0] exp_hash;
    int n, wen, blk_bad, bad;
    bit seen;
    exp_blk = pad_block(digest);
    exp_q.push_back(sha256_block(IV, exp_blk));
    wait_ready();
    bus.in_valid  = 1'b1;
    bus.in_digest = digest;
    bus.in_tag    = tag;
    bus.target    = tgt;
    bus.out_ready = (hold == 0);
    @(posedge CLK);              // input handshake, E0
    @(negedge CLK);              // cycle E0+1
    bus.in_valid  = 1'b0;
    bus.in_digest = {8{$urandom()}};
    bus.target    = '0;
    n = 1; wen = 0; blk_bad = 0; seen = 0;
    while (n <= 200) begin
      if (n == 1) check("in_ready_run", bus.in_ready, 0);
      if (bus.core_write_en) begin
        wen++;
        if (bus.core_block_in !== exp_blk) blk_bad++;
      end
      if (bus.out_valid) begin
        seen = 1;
        break;
      end
      @(negedge CLK);
      n++;
    end
    exp_hash = exp_q.pop_front();
    check("out_valid_seen", seen, 1);
    check("latency", n, 68);
    check("write_en_cycles", wen, 66);
    check("block_stable", blk_bad, 0);
    check("block", bus.core_block_in, exp_blk);
    check("out_hash", bus.out_hash, exp_hash);
    check("out_hit", bus.out_hit, exp_hit);
    check("out_tag", bus.out_tag, tag);
    if (hold > 0) begin
      bus.in_valid  = 1'b1;
      bus.in_digest = {8{$urandom()}};
      bad = 0;
      repeat (hold) begin
        @(negedge CLK);
        if (bus.out_valid !== 1'b1 || bus.out_hash !== exp_hash || bus.out_tag !== tag ||
            bus.out_hit !== exp_hit || bus.in_ready !== 1'b0 || bus.core_write_en !== 1'b0)
          bad++;
      end
      check("backpressure_stable", bad, 0);
      bus.out_ready = 1'b1;
    end
    @(posedge CLK);              // output handshake
    @(negedge CLK);
    check("out_valid_drop", bus.out_valid, 0);
    check("in_ready_after", bus.in_ready, 1);
    check("no_accept_on_handshake", bus.core_write_en, 0);
    bus.in_valid = 1'b0;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [255:0] digest;
    logic [31:0]  tag;
    logic [255:0] tgt;
    logic         exp_hit;
    int           hold;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] d, h, tg;
    logic [31:0]  t;
    int mode;

    vecs[0] = '{ABC_D1, 32'h1234,     {256{1'b1}}, 1'b1, 0};
    vecs[1] = '{ABC_D1, 32'hbeef,     256'h0,      1'b0, 0};
    vecs[2] = '{ABC_D1, 32'h0000_0001, ABC_REV,    1'b1, 0};
    vecs[3] = '{ABC_D1, 32'hffff_fffe, ABC_REV_M1, 1'b0, 0};
    vecs[4] = '{ABC_D1, 32'h5a5a_a5a5, {256{1'b1}}, 1'b1, 20};
    vecs[5] = '{ABC_D1, 32'h1234,     ABC_REV,     1'b1, 0};

    bus.in_valid  = 1'b0;
    bus.in_digest = '0;
    bus.in_tag    = '0;
    bus.target    = '0;
    bus.out_ready = 1'b0;

    // reset values
    repeat (3) @(negedge CLK);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_write_en", bus.core_write_en, 0);
    check("rst_block", bus.core_block_in, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_hash", bus.out_hash, 0);
    check("rst_out_hit", bus.out_hit, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("iv", bus.core_digest_in, IV);
    #2 RST = 1'b1;
    #1 check("rst_release_ready", bus.in_ready, 1);

    // table, back to back
    for (int i = 0; i < 6; i++)
      run_job(vecs[i].digest, vecs[i].tag, vecs[i].tgt, vecs[i].exp_hit, vecs[i].hold);

    // random jobs against the reference model
    for (int r = 0; r < 6; r++) begin
      d    = {8{$urandom()}};
      t    = $urandom();
      h    = rev_bytes(sha256_block(IV, pad_block(d)));
      mode = $urandom_range(0, 3);
      case (mode)
        0: tg = {8{$urandom()}};
        1: tg = h;
        2: tg = h - 256'd1;
        default: tg = h + 256'd1;
      endcase
      run_job(d, t, tg, (h <= tg), $urandom_range(0, 4));
    end

    // reset in the middle of RUN
    wait_ready();
    bus.in_valid  = 1'b1;
    bus.in_digest = ABC_D1;
    bus.in_tag    = 32'h77;
    bus.target    = {256{1'b1}};
    bus.out_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    repeat (29) @(negedge CLK);
    check("mid_run_write_en", bus.core_write_en, 1);
    #2 RST = 1'b0;
    #1;
    check("rst_mid_write_en", bus.core_write_en, 0);
    check("rst_mid_in_ready", bus.in_ready, 0);
    check("rst_mid_out_valid", bus.out_valid, 0);
    repeat (3) @(negedge CLK);
    check("rst_hold_in_ready", bus.in_ready, 0);
    #2 RST = 1'b1;
    #1;
    check("rst_mid_release_ready", bus.in_ready, 1);
    check("rst_mid_release_valid", bus.out_valid, 0);
    check("rst_mid_release_wen", bus.core_write_en, 0);
    @(negedge CLK);
    run_job(ABC_D1, 32'h1234, {256{1'b1}}, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
